// File: rtl/layer1_weight_loader.sv
// Streams one row of weights at a time into a packed row register, then writes each row
// to latch-based weight storage using a SETUP / STROBE / HOLD sequence.

`ifndef RELU_NODES
`define RELU_NODES 4
`endif
`ifndef LAYER_1_BIT_WIDTH
`define LAYER_1_BIT_WIDTH 8
`endif
`ifndef INPUT_LAYER_NODES
`define INPUT_LAYER_NODES 784
`endif

module layer1_weight_loader #(
  parameter int RELU_NODES   = `RELU_NODES,
  parameter int WEIGHT_WIDTH = `LAYER_1_BIT_WIDTH,
  parameter int NODE_COUNT   = `INPUT_LAYER_NODES
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               start,
  input  logic [WEIGHT_WIDTH-1:0]            weightIn,
  input  logic                               weightValid,
  output logic                               weightReady,
  output logic                               writeEnable,
  output logic [9:0]                         NodeSelect,
  output logic [RELU_NODES*WEIGHT_WIDTH-1:0] writeIn,
  output logic                               busy,
  output logic                               loadDone
);

  localparam int BEAT_W = (RELU_NODES > 1) ? $clog2(RELU_NODES) : 1;
  localparam int ROW_W  = (NODE_COUNT > 1) ? $clog2(NODE_COUNT) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RELU_NODES - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(NODE_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_t;

  state_t             state;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [ROW_W-1:0]   row_cnt;

  // NodeSelect and writeIn only move outside the SETUP..HOLD window, so the latch
  // sees stable address and data one cycle before and after its enable strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      row_cnt     <= '0;
      weightReady <= 1'b0;
      writeEnable <= 1'b0;
      NodeSelect  <= '0;
      writeIn     <= '0;
      busy        <= 1'b0;
      loadDone    <= 1'b0;
    end else begin
      loadDone <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= FILL;
            row_cnt     <= '0;
            beat_cnt    <= '0;
            weightReady <= 1'b1;
            busy        <= 1'b1;
          end
        end

        FILL: begin
          if (weightValid && weightReady) begin
            for (int k = 0; k < RELU_NODES; k++) begin
              if (beat_cnt == BEAT_W'(k)) begin
                writeIn[k*WEIGHT_WIDTH +: WEIGHT_WIDTH] <= weightIn;
              end
            end
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt    <= '0;
              weightReady <= 1'b0;
              NodeSelect  <= 10'(row_cnt);
              state       <= SETUP;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end

        SETUP: begin
          writeEnable <= 1'b1;
          state       <= STROBE;
        end

        STROBE: begin
          writeEnable <= 1'b0;
          state       <= HOLD;
        end

        HOLD: begin
          if (row_cnt == LAST_ROW) begin
            busy     <= 1'b0;
            loadDone <= 1'b1;
            state    <= DONE;
          end else begin
            row_cnt     <= row_cnt + 1'b1;
            weightReady <= 1'b1;
            state       <= FILL;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state       <= IDLE;
          weightReady <= 1'b0;
          writeEnable <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer1_weight_loader.sv
// Randomised and directed bench for layer1_weight_loader: a small 3-row instance for
// data, timing, stall, start-ignore and reset cases, and a default 784-row instance.

module tb_layer1_weight_loader;

  localparam int RN = 4;
  localparam int WW = 8;
  localparam int NC = 3;
  localparam int BIG_NC = 784;
  localparam int MAXT = 200;

  logic          clk;
  logic          reset_n;
  logic          start, weight_valid, weight_ready, we, busy, load_done;
  logic [WW-1:0] weight_in;
  logic [9:0]    sel;
  logic [RN*WW-1:0] row;

  logic          start_b, valid_b, ready_b, we_b, busy_b, done_b;
  logic [WW-1:0] in_b;
  logic [9:0]    sel_b;
  logic [RN*WW-1:0] row_b;

  layer1_weight_loader #(.RELU_NODES(RN), .WEIGHT_WIDTH(WW), .NODE_COUNT(NC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .weightIn(weight_in),
    .weightValid(weight_valid), .weightReady(weight_ready), .writeEnable(we),
    .NodeSelect(sel), .writeIn(row), .busy(busy), .loadDone(load_done)
  );

  layer1_weight_loader #(.RELU_NODES(RN), .WEIGHT_WIDTH(WW), .NODE_COUNT(BIG_NC)) dut_big (
    .clk(clk), .reset_n(reset_n), .start(start_b), .weightIn(in_b),
    .weightValid(valid_b), .weightReady(ready_b), .writeEnable(we_b),
    .NodeSelect(sel_b), .writeIn(row_b), .busy(busy_b), .loadDone(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [9:0]       s;
    logic [RN*WW-1:0] r;
  } wr_t;

  wr_t           wq[$];
  int            done_q[$];
  logic [WW-1:0] dat[NC*RN];
  bit            vpat[MAXT];
  int            start_cyc;
  int            exp_t;

  int               wr_b_n = 0, done_b_n = 0, done_b_cyc = 0;
  logic [9:0]       last_sel_b;
  logic [RN*WW-1:0] last_row_b;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cycle monitor: latch-timing rules, ready only while filling, and write/done capture
  bit               have_prev = 0, pend = 0;
  logic [9:0]       prev_sel, pend_sel;
  logic [RN*WW-1:0] prev_row, pend_row;

  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      have_prev = 0;
      pend = 0;
    end else begin
      if (pend) checkOutput("we_hold_after", {sel, row}, {pend_sel, pend_row});
      pend = 0;
      if (we) begin
        checkOutput("we_setup_before", {have_prev, sel, row}, {1'b1, prev_sel, prev_row});
        wq.push_back('{s: sel, r: row});
        pend = 1;
        pend_sel = sel;
        pend_row = row;
      end
      checkOutput("ready_only_in_fill", 64'(weight_ready && !(busy && !we)), 64'd0);
      if (load_done) done_q.push_back(cyc);
      prev_sel = sel;
      prev_row = row;
      have_prev = 1;
      if (we_b) begin
        wr_b_n++;
        last_sel_b = sel_b;
        last_row_b = row_b;
      end
      if (done_b) begin
        done_b_n++;
        done_b_cyc = cyc;
      end
    end
  end

  function automatic logic [RN*WW-1:0] expRow(input int j);
    logic [RN*WW-1:0] r;
    for (int k = 0; k < RN; k++) r[k*WW +: WW] = dat[j*RN + k];
    return r;
  endfunction

  // Edge offset (from the start edge) of the final HOLD exit, i.e. when loadDone appears
  function automatic int modelDone();
    int t = 0;
    for (int j = 0; j < NC; j++) begin
      int beats = 0;
      while (beats < RN && t < MAXT - 1) begin
        t++;
        if (vpat[t]) beats++;
      end
      t += 3;
    end
    return t;
  endfunction

  // mode 0: valid every cycle, 1: valid on odd cycles, 2: random valid
  task automatic applyStimulus(input int mode, input bit poke, input bit abort, output bit aborted);
    int idx = 0;
    bit r;
    bit poked = 0;
    aborted = 0;
    for (int t = 0; t < MAXT; t++)
      vpat[t] = (mode == 0) ? 1'b1 : (mode == 1) ? t[0] : ($urandom_range(3) != 0);
    exp_t = modelDone();
    wq.delete();
    done_q.delete();
    start = 1'b1;
    weight_valid = 1'b0;
    @(posedge clk);
    #2;
    start = 1'b0;
    start_cyc = cyc;
    for (int off = 1; off < MAXT; off++) begin
      r = weight_ready;
      weight_valid = vpat[off];
      weight_in = (idx < NC*RN) ? dat[idx] : '0;
      if (poke && !poked && idx == RN + 1) begin
        start = 1'b1;
        poked = 1;
      end
      @(posedge clk);
      if (r && weight_valid) idx++;
      #2;
      start = 1'b0;
      if (abort && we && sel == 10'd1) begin
        aborted = 1;
        break;
      end
      if (done_q.size() > 0) break;
    end
    weight_valid = 1'b0;
  endtask

  task automatic verifyLoad(input string tag);
    repeat (3) @(posedge clk);
    #2;
    checkOutput({tag, "_write_count"}, 64'(wq.size()), 64'(NC));
    for (int j = 0; j < wq.size() && j < NC; j++) begin
      checkOutput({tag, "_row_sel"}, 64'(wq[j].s), 64'(j));
      checkOutput({tag, "_row_data"}, 64'(wq[j].r), 64'(expRow(j)));
    end
    checkOutput({tag, "_done_count"}, 64'(done_q.size()), 64'd1);
    if (done_q.size() > 0)
      checkOutput({tag, "_latency"}, 64'(done_q[0] - start_cyc + 1), 64'(exp_t + 1));
    checkOutput({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    bit ab;
    reset_n = 1'b0;
    start = 1'b0; weight_valid = 1'b0; weight_in = '0;
    start_b = 1'b0; valid_b = 1'b0; in_b = '0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_ready", 64'(weight_ready), 64'd0);
    checkOutput("rst_we", 64'(we), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(load_done), 64'd0);
    checkOutput("rst_sel", 64'(sel), 64'd0);
    checkOutput("rst_row", 64'(row), 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #2;

    $display("[TB] back-to-back load");
    for (int i = 0; i < NC*RN; i++) dat[i] = WW'(i + 1);
    applyStimulus(0, 0, 0, ab);
    checkOutput("b2b_row0_const", 64'(expRow(0)), 64'h04030201);
    verifyLoad("b2b");
    if (done_q.size() > 0)
      checkOutput("b2b_latency_22", 64'(done_q[0] - start_cyc + 1), 64'd22);

    $display("[TB] toggling valid");
    applyStimulus(1, 0, 0, ab);
    verifyLoad("toggle");

    $display("[TB] start pulsed during row 1 fill");
    for (int i = 0; i < NC*RN; i++) dat[i] = WW'($urandom);
    applyStimulus(0, 1, 0, ab);
    verifyLoad("poke");

    $display("[TB] random valid and data");
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < NC*RN; i++) dat[i] = WW'($urandom);
      applyStimulus(2, 0, 0, ab);
      verifyLoad("rand");
    end

    $display("[TB] reset during row 1 strobe");
    applyStimulus(0, 0, 1, ab);
    checkOutput("abort_reached", 64'(ab), 64'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_we_now", 64'(we), 64'd0);
    checkOutput("abort_busy_now", 64'(busy), 64'd0);
    checkOutput("abort_sel_now", 64'(sel), 64'd0);
    @(posedge clk);
    #2;
    checkOutput("abort_we_next", 64'(we), 64'd0);
    checkOutput("abort_done_next", 64'(load_done), 64'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    checkOutput("abort_no_done", 64'(done_q.size()), 64'd0);
    applyStimulus(0, 0, 0, ab);
    verifyLoad("restart");

    $display("[TB] full default-size load");
    wr_b_n = 0;
    done_b_n = 0;
    start_b = 1'b1;
    @(posedge clk);
    #2;
    start_b = 1'b0;
    start_cyc = cyc;
    valid_b = 1'b1;
    in_b = 8'h7F;
    for (int i = 0; i < 6000 && done_b_n == 0; i++) begin
      @(posedge clk);
      #2;
    end
    valid_b = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    checkOutput("big_writes", 64'(wr_b_n), 64'(BIG_NC));
    checkOutput("big_last_sel", 64'(last_sel_b), 64'h30F);
    checkOutput("big_last_row", 64'(last_row_b), 64'h7F7F7F7F);
    checkOutput("big_done_count", 64'(done_b_n), 64'd1);
    checkOutput("big_busy_after", 64'(busy_b), 64'd0);
    checkOutput("big_latency", 64'(done_b_cyc - start_cyc + 1), 64'(BIG_NC*(RN+3)+1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
